divide: RTL and testbench
=========================

# divide

Sequential sign-magnitude divider, the inverse of the calculator's multiply block. It takes two 16-bit sign-magnitude operands and produces the quotient and, optionally, the remainder using restoring shift-subtract division at one quotient bit per cycle. It uses the same level start / finish handshake as the multiplier, so the calculator control FSM drives both blocks identically.

## Interface
- No parameters; operand width is fixed at 16 bits (1 sign bit plus 15 magnitude bits).
- clk  in  1  rising-edge clock
- RST  in  1  asynchronous reset, active-high
- INn1  in  16  dividend; [15] is the sign, [14:0] is the magnitude
- INn2  in  16  divisor; same format
- start  in  1  level request; sampled in IDLE
- out  out  16  quotient, sign-magnitude, registered
- rem  out  16  remainder, sign-magnitude, registered (see Configuration)
- finish  out  1  high exactly while the FSM is in FIN
- div_zero  out  1  registered; set when the divisor magnitude is 0

## Operation
- **States:** IDLE, SET, ITER, FIN.
- **IDLE:**
  - Goes to SET when start=1.
- **SET:**
  - Captures INn1/INn2 magnitudes and signs. Input changes after SET are ignored.
  - Clears the partial remainder, iteration counter, out, rem and div_zero.
  - If INn2[14:0]==0: go to FIN and set div_zero=1, out=15'h7FFF magnitude, rem=dividend magnitude.
  - Otherwise go to ITER.
- **ITER, each cycle:**
  - trial = {prem[13:0], dvd[14]} − divisor, computed on adder15 in subtract mode.
  - The subtraction is accepted if prem[14]==1 or cOut==1 (no borrow).
  - Accepted: prem ← trial. Rejected: prem ← {prem[13:0], dvd[14]}.
  - In both cases dvd ← {dvd[13:0], accept}. dvd fills with quotient bits.
  - The counter runs 0..14. When count==14, go to FIN.
- **FIN:**
  - On entry, out and rem are loaded with the results.
  - Stays in FIN while start=1. Goes to IDLE on the first edge with start=0.
- **Sign rules (truncating division):**
  - Quotient sign = INn1[15] ^ INn2[15].
  - Remainder sign = INn1[15].
  - Any zero magnitude forces its sign to 0 (no −0 output). This also applies to the divide-by-zero result.
- **Results:**
  - out, rem and div_zero hold their values through FIN and IDLE until the next SET.

## Timing
- Reset values: state=IDLE; out, rem = 16'h0000; finish=0; div_zero=0; all internal registers 0.
- Let edge 0 be the edge that samples start=1 in IDLE.
  - SET occupies cycle 1.
  - ITER occupies edges 2..16.
  - finish first goes high after edge 16, so normal latency is 16 edges.
  - Divide-by-zero: finish goes high after edge 1.
- start dropping during SET or ITER is ignored. The division completes, and finish then pulses for exactly one cycle.
- start held high after FIN keeps finish high indefinitely. A new operation requires start low for at least one edge in FIN, then start high in IDLE.
- RST asserted in any state (including mid-ITER) forces IDLE and the reset values immediately, with no clock needed. After RST deasserts, no stale result and no finish appear.
- finish is decoded from state; the other outputs are registered.

## Configuration
- Macro: `DIVIDE_REMAINDER_EN`.
- Defined: the rem register is built and loaded at FIN as specified above.
- Undefined:
  - No rem register exists. The rem port remains and is tied to 16'h0000.
  - prem is still used internally; the quotient and latency are unchanged.

## Structure
- A shared calc package holds:
  - The state_t enum (IDLE, SET, ITER, FIN; 4-bit encoding, matching the multiplier's style).
  - The width constants MAG_W=15 and WORD_W=16.
  - The divide-by-zero saturation constant 15'h7FFF.
- One sub-module: the existing adder15, instantiated once with sub=1 for the trial subtraction.
- The iteration counter is a plain 4-bit register. It does not use a second adder instance.

## Test plan
- 0x0064 / 0x0007 (100/7) -> out=0x000E, rem=0x0002, div_zero=0; finish rises 16 edges after start is sampled.
- 0x8064 / 0x0007 (−100/7) -> out=0x800E, rem=0x8002. Also 0x0003 / 0x8009 (3/−9) -> out=0x0000, rem=0x0003 (zero-sign normalisation).
- 0x0005 / 0x8000 (divisor −0) -> div_zero=1, out=0x7FFF, rem=0x0005; finish rises after edge 1.
- 0x7FFF / 0x0001 -> out=0x7FFF, rem=0. Also 0x7FFF / 0x7FFF -> out=0x0001, rem=0 (exercises the prem[14] accept path).
- Handshake:
  - Hold start high for 30 cycles -> finish stays high from edge 16 to the end.
  - Drop start -> IDLE on the next edge and finish=0.
  - Re-raise start -> a fresh result.
- Reset mid-operation: assert RST on the 5th ITER cycle -> out, rem, div_zero and finish are 0 immediately. After release, a new 100/7 gives 0x000E.

Source files
------------

// File: rtl/divide_pkg.sv
// Shared calculator definitions for the sequential sign-magnitude divider:
// FSM state encoding, operand widths and the divide-by-zero saturation value.
package divide_pkg;

    localparam int MAG_W  = 15;
    localparam int WORD_W = 16;

    localparam logic [MAG_W-1:0] DIV_ZERO_SAT = 15'h7FFF;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SET  = 4'b0010,
        ITER = 4'b0100,
        FIN  = 4'b1000
    } state_t;

    // Build a sign-magnitude word, never producing negative zero.
    function automatic logic [WORD_W-1:0] sm_pack(input logic sign, input logic [MAG_W-1:0] mag);
        return {sign & (|mag), mag};
    endfunction

endpackage

// File: rtl/adder15.sv
// 15-bit adder/subtractor; in subtract mode cOut=1 means no borrow (a >= b).
module adder15
    import divide_pkg::*;
(
    input  logic [MAG_W-1:0] a,
    input  logic [MAG_W-1:0] b,
    input  logic             sub,
    output logic [MAG_W-1:0] sum,
    output logic             cOut
);

    logic [MAG_W-1:0] b_eff_s;
    logic [MAG_W:0]   full_s;

    assign b_eff_s = sub ? ~b : b;
    assign full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{MAG_W{1'b0}}, sub};
    assign sum     = full_s[MAG_W-1:0];
    assign cOut    = full_s[MAG_W];

endmodule

// File: rtl/divide.sv
// Sequential restoring sign-magnitude divider, one quotient bit per cycle.
// Optional remainder register is built when DIVIDE_REMAINDER_EN is defined.
module divide
    import divide_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic [WORD_W-1:0] INn1,
    input  logic [WORD_W-1:0] INn2,
    input  logic              start,
    output logic [WORD_W-1:0] out,
    output logic [WORD_W-1:0] rem,
    output logic              finish,
    output logic              div_zero
);

    state_t            state_r;
    state_t            state_next_s;
    logic [MAG_W-1:0]  prem_r;
    logic [MAG_W-1:0]  dvd_r;
    logic [MAG_W-1:0]  dvs_r;
    logic [3:0]        count_r;
    logic              q_sign_r;
    logic [WORD_W-1:0] out_r;
    logic              div_zero_r;

    logic [MAG_W-1:0]  shift_s;
    logic [MAG_W-1:0]  trial_s;
    logic              c_out_s;
    logic              accept_s;
    logic [MAG_W-1:0]  prem_next_s;
    logic [MAG_W-1:0]  dvd_next_s;
    logic              divisor_zero_s;
    logic              last_iter_s;
    logic              dvd_sign_s;

    assign divisor_zero_s = (INn2[MAG_W-1:0] == {MAG_W{1'b0}});
    assign last_iter_s    = (count_r == 4'd14);
    assign dvd_sign_s     = INn1[WORD_W-1] & (|INn1[MAG_W-1:0]);

    // Next partial remainder: shift in the next dividend bit, subtract the divisor.
    assign shift_s = {prem_r[MAG_W-2:0], dvd_r[MAG_W-1]};

    adder15 u_trial (
        .a    (shift_s),
        .b    (dvs_r),
        .sub  (1'b1),
        .sum  (trial_s),
        .cOut (c_out_s)
    );

    // The bit shifted out of prem makes the shifted value exceed any 15-bit divisor.
    assign accept_s    = prem_r[MAG_W-1] | c_out_s;
    assign prem_next_s = accept_s ? trial_s : shift_s;
    assign dvd_next_s  = {dvd_r[MAG_W-2:0], accept_s};

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = SET;
                else       state_next_s = IDLE;
            end
            SET: begin
                if (divisor_zero_s) state_next_s = FIN;
                else                state_next_s = ITER;
            end
            ITER: begin
                if (last_iter_s) state_next_s = FIN;
                else             state_next_s = ITER;
            end
            FIN: begin
                if (start) state_next_s = FIN;
                else       state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and quotient result registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            prem_r     <= {MAG_W{1'b0}};
            dvd_r      <= {MAG_W{1'b0}};
            dvs_r      <= {MAG_W{1'b0}};
            count_r    <= 4'd0;
            q_sign_r   <= 1'b0;
            out_r      <= {WORD_W{1'b0}};
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                SET: begin
                    dvd_r    <= INn1[MAG_W-1:0];
                    dvs_r    <= INn2[MAG_W-1:0];
                    q_sign_r <= INn1[WORD_W-1] ^ INn2[WORD_W-1];
                    prem_r   <= {MAG_W{1'b0}};
                    count_r  <= 4'd0;
                    if (divisor_zero_s) begin
                        div_zero_r <= 1'b1;
                        out_r      <= sm_pack(dvd_sign_s, DIV_ZERO_SAT);
                    end else begin
                        div_zero_r <= 1'b0;
                        out_r      <= {WORD_W{1'b0}};
                    end
                end
                ITER: begin
                    prem_r  <= prem_next_s;
                    dvd_r   <= dvd_next_s;
                    count_r <= count_r + 4'd1;
                    if (last_iter_s) begin
                        out_r <= sm_pack(q_sign_r, dvd_next_s);
                    end else begin
                        out_r <= out_r;
                    end
                end
                default: begin
                    prem_r <= prem_r;
                end
            endcase
        end
    end

`ifdef DIVIDE_REMAINDER_EN
    logic [WORD_W-1:0] rem_r;
    logic              r_sign_r;

    // Remainder result register; takes the dividend sign (truncating division).
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rem_r    <= {WORD_W{1'b0}};
            r_sign_r <= 1'b0;
        end else begin
            case (state_r)
                SET: begin
                    r_sign_r <= INn1[WORD_W-1];
                    if (divisor_zero_s) rem_r <= sm_pack(INn1[WORD_W-1], INn1[MAG_W-1:0]);
                    else                rem_r <= {WORD_W{1'b0}};
                end
                ITER: begin
                    if (last_iter_s) rem_r <= sm_pack(r_sign_r, prem_next_s);
                    else             rem_r <= rem_r;
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    assign rem = rem_r;
`else
    assign rem = 16'h0000;
`endif

    assign out      = out_r;
    assign div_zero = div_zero_r;
    assign finish   = (state_r == FIN);

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: driver pushes expected results, monitor checks on finish.
module tb_divide;

    logic        clk;
    logic        RST;
    logic [15:0] INn1;
    logic [15:0] INn2;
    logic        start;
    logic [15:0] out;
    logic [15:0] rem;
    logic        finish;
    logic        div_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
        int          start_edge;
    } exp_t;

    exp_t sb_q[$];
    logic fin_prev = 1'b0;

    divide dut (
        .clk      (clk),
        .RST      (RST),
        .INn1     (INn1),
        .INn2     (INn2),
        .start    (start),
        .out      (out),
        .rem      (rem),
        .finish   (finish),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer division on magnitudes, then the sign rules.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int se);
        exp_t e;
        int m1, m2, q, r;
        logic s1, s2, qs;
        m1 = int'(a[14:0]);
        m2 = int'(b[14:0]);
        s1 = a[15] && (m1 != 0);
        s2 = b[15] && (m2 != 0);
        if (m2 == 0) begin
            q = 32767; r = m1; e.dz = 1'b1; e.lat = 1;
        end else begin
            q = m1 / m2; r = m1 % m2; e.dz = 1'b0; e.lat = 16;
        end
        qs = (s1 ^ s2) && (q != 0);
        e.q = {qs, q[14:0]};
`ifdef DIVIDE_REMAINDER_EN
        e.r = {a[15] && (r != 0), r[14:0]};
`else
        e.r = 16'h0000;
`endif
        e.start_edge = se;
        return e;
    endfunction

    // Monitor: each rising finish must match the oldest outstanding request.
    always @(negedge clk) begin
        if (finish && !fin_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_finish", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out", {16'h0, out}, {16'h0, e.q});
                check("rem", {16'h0, rem}, {16'h0, e.r});
                check("div_zero", {31'h0, div_zero}, {31'h0, e.dz});
                check("latency", cyc - e.start_edge, e.lat);
            end
        end
        fin_prev <= finish;
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit early);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        INn1  = a;
        INn2  = b;
        start = 1'b1;
        sb_q.push_back(model(a, b, cyc + 1));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (early && k == 0) start = 1'b0;
            if (k == 2) begin
                INn1 = 16'($urandom);
                INn2 = 16'($urandom);
            end
            if (finish) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("finish_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("finish_held", {31'h0, finish}, 32'd1);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("finish_drop", {31'h0, finish}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RST   = 1'b0;
        start = 1'b0;
        INn1  = 16'h0000;
        INn2  = 16'h0000;
        #1 RST = 1'b1;
        #1;
        check("rst_out", {16'h0, out}, 32'd0);
        check("rst_rem", {16'h0, rem}, 32'd0);
        check("rst_dz", {31'h0, div_zero}, 32'd0);
        check("rst_finish", {31'h0, finish}, 32'd0);
        repeat (2) @(negedge clk);
        RST = 1'b0;

        do_op(16'h0064, 16'h0007, 0, 1'b0);
        do_op(16'h8064, 16'h0007, 1, 1'b0);
        do_op(16'h0003, 16'h8009, 0, 1'b1);
        do_op(16'h7FFF, 16'h0001, 2, 1'b0);
        do_op(16'h7FFF, 16'h7FFF, 0, 1'b0);
        do_op(16'h0064, 16'h0007, 30, 1'b0);
        do_op(16'h1234, 16'h0010, 0, 1'b0);
        do_op(16'h0005, 16'h8000, 3, 1'b0);

        // Held divide-by-zero result must be cleared asynchronously.
        #1 RST = 1'b1;
        #1;
        check("rst_hold_out", {16'h0, out}, 32'd0);
        check("rst_hold_dz", {31'h0, div_zero}, 32'd0);
        check("rst_hold_rem", {16'h0, rem}, 32'd0);
        @(negedge clk);
        RST = 1'b0;

        // Reset on the 5th ITER cycle of a 100/7 request.
        do_op(16'h0064, 16'h0007, 0, 1'b0);
        @(negedge clk);
        INn1  = 16'h0064;
        INn2  = 16'h0007;
        start = 1'b1;
        repeat (6) @(negedge clk);
        #1 RST = 1'b1;
        start = 1'b0;
        #1;
        check("mid_rst_out", {16'h0, out}, 32'd0);
        check("mid_rst_rem", {16'h0, rem}, 32'd0);
        check("mid_rst_dz", {31'h0, div_zero}, 32'd0);
        check("mid_rst_finish", {31'h0, finish}, 32'd0);
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_no_finish", {31'h0, finish}, 32'd0);
        end
        do_op(16'h0064, 16'h0007, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b[14:0] = 15'($urandom_range(0, 15));
                1: b[14:0] = 15'($urandom_range(1, 300));
                2: a[14:0] = 15'($urandom_range(0, 20));
                default: a[15] = a[15];
            endcase
            do_op(a, b, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
